sf48_sequencer: RTL

Sample-rate controller for the stereo sum/difference stage of the FM modulator. It generates the 48 kHz sample strobe from the system clock and accepts left/right audio samples through a valid/ready handshake. At each strobe it time-shares one multiplier to produce the gain-scaled L+R and L−R words that feed the pilot/subcarrier mixer. Gain values are runtime-configurable through shadow registers that are applied on sample boundaries.

---
 rtl/sf48_sequencer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/sf48_sequencer.sv
// 48 kHz sample sequencer: strobe generation, one-entry L/R input buffer and a
// time-shared multiplier producing gain-scaled, saturated L+R and L-R words.
module sf48_sequencer #(
    parameter int         DIV     = 2083,
    parameter logic [7:0] KS_INIT = 8'd70,
    parameter logic [7:0] KD_INIT = 8'd70
) (
    input  logic               clock,
    input  logic               reset,
    input  logic signed [17:0] left,
    input  logic signed [17:0] right,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               cfg_we,
    input  logic               cfg_sel,
    input  logic [7:0]         cfg_data,
    output logic               tick,
    output logic signed [17:0] sum_out,
    output logic signed [17:0] dif_out,
    output logic               out_valid,
    output logic               underrun
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MUL_S = 2'd1;
    localparam logic [1:0] S_MUL_D = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    logic [CW-1:0]      cnt_q, cnt_d;
    logic [1:0]         state_q, state_d;
    logic               full_q, full_d;
    logic               under_q, under_d;
    logic signed [17:0] bl_q, br_q;
    logic signed [17:0] wl_q, wl_d, wr_q, wr_d;
    logic [7:0]         ks_sh_q, ks_sh_d, kd_sh_q, kd_sh_d;
    logic [7:0]         ks_q, ks_d, kd_q, kd_d;
    logic signed [27:0] ps_q;
    logic signed [17:0] sum_q, sum_d, dif_q, dif_d;
    logic signed [18:0] op_a;
    logic signed [8:0]  op_b;
    logic signed [27:0] prod;
    logic               xfer;

    // Floor-divide by 128 (arithmetic shift) and clamp to the 18-bit signed range.
    function automatic logic signed [17:0] scale_sat(input logic signed [27:0] p);
        logic signed [27:0] sh;
        sh = p >>> 7;
        if (sh > 28'sd131071)
            scale_sat = 18'sh1FFFF;
        else if (sh < -28'sd131072)
            scale_sat = 18'sh20000;
        else
            scale_sat = sh[17:0];
    endfunction

    assign tick      = (cnt_q == CW'(DIV - 1));
    assign in_ready  = reset & ~full_q;
    assign xfer      = in_valid & in_ready;
    assign out_valid = (state_q == S_OUT);
    assign sum_out   = sum_q;
    assign dif_out   = dif_q;
    assign underrun  = under_q;

    // One multiplier, shared between the sum and difference phases.
    always_comb begin
        if (state_q == S_MUL_D) begin
            op_a = {wl_q[17], wl_q} - {wr_q[17], wr_q};
            op_b = {1'b0, kd_q};
        end else begin
            op_a = {wl_q[17], wl_q} + {wr_q[17], wr_q};
            op_b = {1'b0, ks_q};
        end
        prod = op_a * op_b;
    end

    always_comb begin
        cnt_d   = tick ? '0 : cnt_q + 1'b1;
        state_d = state_q;
        full_d  = full_q;
        under_d = under_q;
        wl_d    = wl_q;
        wr_d    = wr_q;
        ks_sh_d = ks_sh_q;
        kd_sh_d = kd_sh_q;
        ks_d    = ks_q;
        kd_d    = kd_q;
        sum_d   = sum_q;
        dif_d   = dif_q;

        if (cfg_we) begin
            if (cfg_sel) kd_sh_d = cfg_data;
            else         ks_sh_d = cfg_data;
        end
        if (xfer)
            full_d = 1'b1;

        case (state_q)
            S_IDLE: if (tick) begin
                // Gains latch the shadow value from before any same-cycle write.
                ks_d    = ks_sh_q;
                kd_d    = kd_sh_q;
                state_d = S_MUL_S;
                if (full_q) begin
                    wl_d   = bl_q;
                    wr_d   = br_q;
                    full_d = 1'b0;
                end else begin
                    under_d = 1'b1;
                end
            end
            S_MUL_S: state_d = S_MUL_D;
            S_MUL_D: begin
                sum_d   = scale_sat(ps_q);
                dif_d   = scale_sat(prod);
                state_d = S_OUT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
            full_q  <= 1'b0;
            under_q <= 1'b0;
            wl_q    <= '0;
            wr_q    <= '0;
            ks_sh_q <= KS_INIT;
            kd_sh_q <= KD_INIT;
            ks_q    <= KS_INIT;
            kd_q    <= KD_INIT;
            sum_q   <= '0;
            dif_q   <= '0;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
            full_q  <= full_d;
            under_q <= under_d;
            wl_q    <= wl_d;
            wr_q    <= wr_d;
            ks_sh_q <= ks_sh_d;
            kd_sh_q <= kd_sh_d;
            ks_q    <= ks_d;
            kd_q    <= kd_d;
            sum_q   <= sum_d;
            dif_q   <= dif_d;
        end
    end

    always_ff @(posedge clock) begin
        if (xfer) begin
            bl_q <= left;
            br_q <= right;
        end
        if (state_q == S_MUL_S)
            ps_q <= prod;
    end
endmodule
